// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath.
//
// master : controller side (multicycle_control_fsm) - reads opcode/zero, drives controls
// slave  : datapath side - drives opcode/zero, reads controls
//
// Signals:
//   opcode      instruction register bits [31:26]
//   zero        ALU zero flag
//   pc_write    PC load enable
//   i_or_d      memory address select (0 = PC, 1 = ALUOut)
//   mem_write   memory write enable
//   ir_write    instruction register load enable
//   reg_dst     write register select (0 = rt, 1 = rd)
//   mem_to_reg  write-back data select (0 = ALUOut, 1 = MDR)
//   reg_write   register file write enable
//   alu_src_a   ALU A select (0 = PC, 1 = A register)
//   alu_src_b   ALU B select (00 B, 01 4, 10 sext imm, 11 sext imm << 2)
//   alu_op      00 add, 01 subtract, 10 decode funct
//   pc_source   00 ALU result, 01 ALUOut, 10 jump target
//   instr_done  high on the last cycle of each instruction
//   illegal_op  high in the ILLEGAL state
//   state       current state encoding (debug)
interface multicycle_control_fsm_if;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_write;
  logic       i_or_d;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero,
    output pc_write, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op, state
  );

  modport slave (
    output opcode, zero,
    input  pc_write, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle MIPS datapath. Steps each instruction through
// fetch / decode / execute / memory / write-back and drives every datapath select and
// write enable.
//
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous, active-high; forces every output to 0 while high
//   bus_io  multicycle_control_fsm_if.master (opcode, zero in; controls, state out)
//
// Build option:
//   CTRL_BNE_EN  when defined, opcode 000101 (bne) dispatches to BRANCH and branches
//                on ~zero; when undefined, bne is treated as an illegal opcode.
module multicycle_control_fsm (
  input logic                        clk,
  input logic                        reset,
  multicycle_control_fsm_if.master   bus_io
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StAddiExec = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11,
    StIllegal  = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef CTRL_BNE_EN
  localparam logic [5:0] OpBne   = 6'b000101;
`endif

  // Moore control word for a state. BRANCH pc_write is left 0 here; it is resolved
  // combinationally from zero at the output.
  function automatic ctrl_t decode_ctrl(state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch: begin
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_write  = 1'b1;
      end
      StDecode:   c.alu_src_b = 2'b11;
      StMemAddr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      StMemRead:  c.i_or_d = 1'b1;
      StMemWb: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      StMemWrite: begin
        c.i_or_d     = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      StRExec: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      StRWb: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      StBranch: begin
        c.alu_src_a  = 1'b1;
        c.alu_op     = 2'b01;
        c.pc_source  = 2'b01;
        c.instr_done = 1'b1;
      end
      StAddiExec: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      StAddiWb: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      StJump: begin
        c.pc_source  = 2'b10;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
      end
      StIllegal: begin
        c.illegal_op = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  ctrl_t  ctrl_out;
  logic   branch_pc_write;

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:    state_d = StDecode;
      StDecode: begin
        case (bus_io.opcode)
          OpRType:    state_d = StRExec;
          OpLw, OpSw: state_d = StMemAddr;
          OpBeq:      state_d = StBranch;
`ifdef CTRL_BNE_EN
          OpBne:      state_d = StBranch;
`endif
          OpAddi:     state_d = StAddiExec;
          OpJ:        state_d = StJump;
          default:    state_d = StIllegal;
        endcase
      end
      StMemAddr:  state_d = (bus_io.opcode == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StRExec:    state_d = StRWb;
      StAddiExec: state_d = StAddiWb;
      default:    state_d = StFetch;
    endcase
    // Outputs are registered alongside the state so they line up with state_q.
    ctrl_d = decode_ctrl(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      ctrl_q  <= decode_ctrl(StFetch);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
`ifdef CTRL_BNE_EN
    branch_pc_write = (bus_io.opcode == OpBne) ? ~bus_io.zero : bus_io.zero;
`else
    branch_pc_write = bus_io.zero;
`endif
    ctrl_out = ctrl_q;
    if (state_q == StBranch) begin
      ctrl_out.pc_write = branch_pc_write;
    end
    // Reset silences everything immediately, including the cycle before the state
    // register has been reloaded.
    if (reset) begin
      ctrl_out = '0;
    end
  end

  assign bus_io.pc_write   = ctrl_out.pc_write;
  assign bus_io.i_or_d     = ctrl_out.i_or_d;
  assign bus_io.mem_write  = ctrl_out.mem_write;
  assign bus_io.ir_write   = ctrl_out.ir_write;
  assign bus_io.reg_dst    = ctrl_out.reg_dst;
  assign bus_io.mem_to_reg = ctrl_out.mem_to_reg;
  assign bus_io.reg_write  = ctrl_out.reg_write;
  assign bus_io.alu_src_a  = ctrl_out.alu_src_a;
  assign bus_io.alu_src_b  = ctrl_out.alu_src_b;
  assign bus_io.alu_op     = ctrl_out.alu_op;
  assign bus_io.pc_source  = ctrl_out.pc_source;
  assign bus_io.instr_done = ctrl_out.instr_done;
  assign bus_io.illegal_op = ctrl_out.illegal_op;
  assign bus_io.state      = reset ? 4'd0 : state_q;

endmodule
